pc_next_unit: RTL and testbench
===============================

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 SHALL provide parameter RESET_VECTOR, default 16'h0000, meaning PC value loaded on reset.
REQ-002 SHALL provide parameter PC_STEP, default 16'd2, meaning sequential PC increment in bytes.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-low.
REQ-005 SHALL have port mem_ready  input  1  meaning instruction memory accepts the fetch at pc this cycle.
REQ-006 SHALL have port stall  input  1  meaning hazard hold request from decode.
REQ-007 SHALL have port branch_en  input  1  meaning conditional branch taken.
REQ-008 SHALL have port offset_shifted  input  16  meaning sign-extended branch offset already shifted left by 1 (shift_left output).
REQ-009 SHALL have port jump_en  input  1  meaning unconditional jump request.
REQ-010 SHALL have port jump_target  input  16  meaning absolute jump address.
REQ-011 SHALL have port halt  input  1  meaning halt instruction decoded.
REQ-012 SHALL have port pc  output  16  meaning current fetch address, registered.
REQ-013 SHALL have port pc_plus  output  16  meaning pc + PC_STEP, combinational, mod 2^16.
REQ-014 SHALL have port fetch_valid  output  1  meaning pc is a valid fetch request.
REQ-015 SHALL have port redirect  output  1  meaning one-cycle pulse: pc was loaded by branch/jump on the previous edge.
REQ-016 SHALL have port halted  output  1  meaning unit is in HALT state.
REQ-017 SHALL have port fetch_count  output  16  meaning count of accepted sequential fetches.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, HALT; IDLE -> RUN unconditionally on the first edge after reset release.
REQ-019 SHALL hold pc, clear fetch_valid, and ignore all control inputs while in IDLE.
REQ-020 SHALL assert fetch_valid=1 only in RUN, combinationally decoded from state.
REQ-021 SHALL apply next-pc priority in RUN: halt > jump_en > branch_en > stall > mem_ready.
REQ-022 SHALL, on halt in RUN: hold pc, go HALT; pending jump/branch that cycle is discarded.
REQ-023 SHALL, on jump_en: pc <= {jump_target[15:1],1'b0}, regardless of stall or mem_ready.
REQ-024 SHALL, on branch_en (no jump): pc <= (pc + PC_STEP + offset_shifted) mod 2^16, bit0 forced 0, regardless of stall or mem_ready.
REQ-025 SHALL, on stall (no redirect): hold pc; fetch_count unchanged.
REQ-026 SHALL, when none of the above and mem_ready=1: pc <= pc_plus, fetch_count <= fetch_count+1 (wrap 16'hFFFF -> 16'h0000).
REQ-027 SHALL, when mem_ready=0 and no other request: hold pc, fetch_count unchanged.
REQ-028 SHALL register redirect=1 for exactly the cycle following a jump/branch load; back-to-back redirects give consecutive pulses.
REQ-029 SHALL wrap all address arithmetic silently (e.g. 16'hFFFE + 2 = 16'h0000); no overflow flag.
REQ-030 SHALL stay in HALT until reset: pc held, fetch_valid=0, halted=1, redirect=0, all inputs ignored.

Reset
REQ-031 SHALL, on any edge with rst=0, regardless of state or mid-redirect: pc=RESET_VECTOR, state=IDLE, fetch_valid=0, redirect=0, halted=0, fetch_count=0.
REQ-032 SHALL give reset precedence over every other input on the same edge.

Verification
REQ-033 SHALL cover sequential run: reset, mem_ready=1 for 4 edges after IDLE -> pc 0000,0002,0004,0006,0008; fetch_count=4.
REQ-034 SHALL cover branch: pc=0010, branch_en=1, offset_shifted=16'hFFF8 -> pc=000A next edge, redirect=1 one cycle, fetch_count unchanged.
REQ-035 SHALL cover jump vs stall: pc=0020, jump_en=1, stall=1, jump_target=16'h1235 -> pc=1234, redirect=1.
REQ-036 SHALL cover stall/mem_ready hold: stall=1 three edges then mem_ready=0 two edges -> pc constant, fetch_count constant.
REQ-037 SHALL cover halt: halt=1 with jump_en=1 at pc=0040 -> pc stays 0040, halted=1, fetch_valid=0; further jumps ignored until rst=0.
REQ-038 SHALL cover wrap and reset mid-operation: pc=FFFE, mem_ready=1 -> pc=0000; then rst=0 with branch_en=1 -> pc=RESET_VECTOR, redirect=0, fetch_count=0.

Source files
------------

// File: rtl/pc_next_unit.sv
// pc_next_unit: program-counter sequencer for the fetch stage.
// Each rising edge it picks the next fetch address in this priority order:
// halt, jump, branch, stall, then sequential advance on mem_ready.
// Ports:
//   clk            - clock, all state updates on the rising edge
//   rst            - synchronous active-low reset
//   mem_ready      - instruction memory accepts the fetch at pc this cycle
//   stall          - hold request from decode
//   branch_en      - conditional branch taken
//   offset_shifted - sign-extended branch offset, already shifted left by 1
//   jump_en        - unconditional jump request
//   jump_target    - absolute jump address (bit 0 is ignored)
//   halt           - halt instruction decoded
//   pc             - current fetch address (registered)
//   pc_plus        - pc + PC_STEP (combinational)
//   fetch_valid    - pc is a valid fetch request (decoded from state)
//   redirect       - pulse: pc was loaded by a jump/branch on the previous edge
//   halted         - unit is in HALT (decoded from state)
//   fetch_count    - number of accepted sequential fetches
module pc_next_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] PC_STEP      = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ready,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [15:0] offset_shifted,
  input  logic        jump_en,
  input  logic [15:0] jump_target,
  input  logic        halt,
  output logic [15:0] pc,
  output logic [15:0] pc_plus,
  output logic        fetch_valid,
  output logic        redirect,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned AW = 16;
  localparam logic [AW-1:0] ALIGN_MASK = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] branch_target;
  logic [AW-1:0] jump_aligned;

  // Address arithmetic wraps mod 2^16; targets are forced halfword aligned.
  assign pc_plus       = pc + PC_STEP;
  assign branch_target = (pc_plus + offset_shifted) & ALIGN_MASK;
  assign jump_aligned  = jump_target & ALIGN_MASK;

  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);

  // State, pc, redirect pulse and fetch counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      redirect    <= 1'b0;
      fetch_count <= '0;
    end else begin
      redirect <= 1'b0;
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (halt) begin
            state <= HALT;
          end else if (jump_en) begin
            pc       <= jump_aligned;
            redirect <= 1'b1;
          end else if (branch_en) begin
            pc       <= branch_target;
            redirect <= 1'b1;
          end else if (!stall && mem_ready) begin
            pc          <= pc_plus;
            fetch_count <= fetch_count + AW'(1);
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus a randomized
// run compared against a behavioural model of the next-pc rules.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready;
  logic        stall;
  logic        branch_en;
  logic [15:0] offset_shifted;
  logic        jump_en;
  logic [15:0] jump_target;
  logic        halt;
  logic [15:0] pc;
  logic [15:0] pc_plus;
  logic        fetch_valid;
  logic        redirect;
  logic        halted;
  logic [15:0] fetch_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int          m_mode;
  logic [15:0] m_pc;
  logic [15:0] m_cnt;
  logic        m_redir;

  pc_next_unit dut (
    .clk            (clk),
    .rst            (rst),
    .mem_ready      (mem_ready),
    .stall          (stall),
    .branch_en      (branch_en),
    .offset_shifted (offset_shifted),
    .jump_en        (jump_en),
    .jump_target    (jump_target),
    .halt           (halt),
    .pc             (pc),
    .pc_plus        (pc_plus),
    .fetch_valid    (fetch_valid),
    .redirect       (redirect),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // One clock edge: advance the model with the inputs the DUT saw, then settle.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_mode = 0; m_pc = 16'h0000; m_cnt = 16'h0000; m_redir = 1'b0;
    end else begin
      m_redir = 1'b0;
      if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (halt) begin
          m_mode = 2;
        end else if (jump_en) begin
          m_pc = jump_target & 16'hFFFE;
          m_redir = 1'b1;
        end else if (branch_en) begin
          m_pc = 16'((int'(m_pc) + 2 + int'(offset_shifted)) % 65536) & 16'hFFFE;
          m_redir = 1'b1;
        end else if (!stall && mem_ready) begin
          m_pc = 16'((int'(m_pc) + 2) % 65536);
          m_cnt = 16'((int'(m_cnt) + 1) % 65536);
        end
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    mem_ready = 0; stall = 0; branch_en = 0; offset_shifted = 0;
    jump_en = 0; jump_target = 0; halt = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 0;
    tick();
    rst = 1;
  endtask

  task automatic do_jump(input logic [15:0] tgt);
    jump_en = 1; jump_target = tgt;
    tick();
    jump_en = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    mem_ready = 1; branch_en = 1; jump_en = 1;
    rst = 0;
    tick();
    n_tests++;
    if (pc !== 16'h0000 || fetch_valid !== 1'b0 || redirect !== 1'b0 ||
        halted !== 1'b0 || fetch_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset: pc=%h fv=%b redir=%b halted=%b cnt=%h, required pc=0000 fv=0 redir=0 halted=0 cnt=0000",
               pc, fetch_valid, redirect, halted, fetch_count);
    end
    n_tests++;
    if (pc_plus !== 16'h0002) begin
      n_fail++; $display("FAIL reset_pc_plus: got %h required 0002", pc_plus);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    mem_ready = 1;
    tick();  // IDLE -> RUN, inputs ignored
    n_tests++;
    if (pc !== 16'h0000 || fetch_valid !== 1'b1 || fetch_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL idle_ignore: pc=%h fv=%b cnt=%h required pc=0000 fv=1 cnt=0000", pc, fetch_valid, fetch_count);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (pc !== 16'(2 * i)) begin
        n_fail++; $display("FAIL seq_pc[%0d]: got %h required %h", i, pc, 16'(2 * i));
      end
    end
    n_tests++;
    if (fetch_count !== 16'd4) begin
      n_fail++; $display("FAIL seq_count: got %0d required 4", fetch_count);
    end
  endtask

  task automatic test_branch();
    logic [15:0] cnt0;
    do_jump(16'h0010);
    n_tests++;
    if (pc !== 16'h0010 || redirect !== 1'b1) begin
      n_fail++; $display("FAIL jump_setup: pc=%h redir=%b required pc=0010 redir=1", pc, redirect);
    end
    cnt0 = fetch_count;
    branch_en = 1; offset_shifted = 16'hFFF8; mem_ready = 1;
    tick();
    branch_en = 0; mem_ready = 0;
    n_tests++;
    if (pc !== 16'h000A || redirect !== 1'b1 || fetch_count !== cnt0) begin
      n_fail++;
      $display("FAIL branch: pc=%h redir=%b cnt=%h required pc=000A redir=1 cnt=%h", pc, redirect, fetch_count, cnt0);
    end
    tick();
    n_tests++;
    if (redirect !== 1'b0 || pc !== 16'h000A) begin
      n_fail++; $display("FAIL branch_pulse_end: redir=%b pc=%h required redir=0 pc=000A", redirect, pc);
    end
  endtask

  task automatic test_jump_vs_stall();
    do_jump(16'h0020);
    jump_en = 1; stall = 1; mem_ready = 1; jump_target = 16'h1235;
    tick();
    jump_en = 0; stall = 0; mem_ready = 0;
    n_tests++;
    if (pc !== 16'h1234 || redirect !== 1'b1) begin
      n_fail++; $display("FAIL jump_stall: pc=%h redir=%b required pc=1234 redir=1", pc, redirect);
    end
  endtask

  task automatic test_hold();
    logic [15:0] pc0, cnt0;
    pc0 = pc; cnt0 = fetch_count;
    stall = 1; mem_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    stall = 0; mem_ready = 0;
    for (int i = 0; i < 2; i++) tick();
    n_tests++;
    if (pc !== pc0 || fetch_count !== cnt0 || redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: pc=%h cnt=%h redir=%b required pc=%h cnt=%h redir=0", pc, fetch_count, redirect, pc0, cnt0);
    end
  endtask

  task automatic test_halt();
    do_jump(16'h0040);
    halt = 1; jump_en = 1; jump_target = 16'h1000;
    tick();
    halt = 0;
    n_tests++;
    if (pc !== 16'h0040 || halted !== 1'b1 || fetch_valid !== 1'b0 || redirect !== 1'b0) begin
      n_fail++;
      $display("FAIL halt: pc=%h halted=%b fv=%b redir=%b required pc=0040 halted=1 fv=0 redir=0",
               pc, halted, fetch_valid, redirect);
    end
    branch_en = 1; mem_ready = 1;
    for (int i = 0; i < 3; i++) tick();
    clear_inputs();
    n_tests++;
    if (pc !== 16'h0040 || halted !== 1'b1 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL halt_sticky: pc=%h halted=%b redir=%b required pc=0040 halted=1 redir=0", pc, halted, redirect);
    end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    tick();
    do_jump(16'hFFFE);
    mem_ready = 1;
    tick();
    n_tests++;
    if (pc !== 16'h0000 || fetch_count !== 16'd1) begin
      n_fail++; $display("FAIL wrap: pc=%h cnt=%h required pc=0000 cnt=0001", pc, fetch_count);
    end
    branch_en = 1; offset_shifted = 16'h0100;
    tick();
    n_tests++;
    if (pc !== 16'h0102 || redirect !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_branch: pc=%h redir=%b required pc=0102 redir=1", pc, redirect);
    end
    rst = 0;
    tick();
    rst = 1; clear_inputs();
    n_tests++;
    if (pc !== 16'h0000 || redirect !== 1'b0 || fetch_count !== 16'h0000 || fetch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: pc=%h redir=%b cnt=%h fv=%b required pc=0000 redir=0 cnt=0000 fv=0",
               pc, redirect, fetch_count, fetch_valid);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst            = ($urandom_range(0, 59) != 0);
      halt           = ($urandom_range(0, 49) == 0);
      jump_en        = ($urandom_range(0, 7) == 0);
      branch_en      = ($urandom_range(0, 5) == 0);
      stall          = ($urandom_range(0, 3) == 0);
      mem_ready      = ($urandom_range(0, 3) != 0);
      jump_target    = 16'($urandom);
      offset_shifted = 16'($urandom) & 16'hFFFE;
      tick();
      n_tests++;
      if (pc !== m_pc || pc_plus !== 16'(m_pc + 16'd2) || fetch_count !== m_cnt ||
          redirect !== m_redir || fetch_valid !== (m_mode == 1) || halted !== (m_mode == 2)) begin
        n_fail++;
        if (errs < 10)
          $display("FAIL random[%0d]: pc=%h pcp=%h cnt=%h redir=%b fv=%b halted=%b required pc=%h pcp=%h cnt=%h redir=%b fv=%b halted=%b",
                   i, pc, pc_plus, fetch_count, redirect, fetch_valid, halted,
                   m_pc, 16'(m_pc + 16'd2), m_cnt, m_redir, (m_mode == 1), (m_mode == 2));
        errs++;
      end
    end
    rst = 1; clear_inputs();
  endtask

  initial begin
    m_mode = 0; m_pc = 0; m_cnt = 0; m_redir = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump_vs_stall();
    test_hold();
    test_halt();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
